// File: rtl/sprite_compositor.sv
// Sprite compositor: layers NUM_SPR ROM-backed sprites, an overlay window and a
// full-screen background into one registered 12-bit pixel, three clocks after the
// pixel coordinates are presented. Sprite config is shadowed and copied to the
// active set only on a frame boundary, so a frame never shows a half-applied update.
module sprite_compositor #(
  parameter int          NUM_SPR    = 4,
  parameter int          SPR_W      = 40,
  parameter int          SPR_H      = 40,
  parameter int          SPR_AW     = 11,
  parameter int          OVL_X0     = 220,
  parameter int          OVL_Y0     = 190,
  parameter int          OVL_W      = 200,
  parameter int          OVL_H      = 100,
  parameter int          OVL_AW     = 15,
  parameter int          BG_AW      = 19,
  parameter logic [11:0] TRANSP_KEY = 12'h000,
  localparam int         IDX_W      = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [9:0]                pixel_x,
  input  logic [9:0]                pixel_y,
  input  logic                      video_on,
  input  logic                      hsync_i,
  input  logic                      vsync_i,
  input  logic                      frame_start,
  input  logic                      cfg_we,
  input  logic [IDX_W-1:0]          cfg_idx,
  input  logic [10:0]               cfg_x,
  input  logic [9:0]                cfg_y,
  input  logic                      cfg_en,
  input  logic                      cfg_commit,
  output logic                      commit_ack,
  input  logic                      ovl_en,
  output logic [NUM_SPR*SPR_AW-1:0] spr_addr,
  input  logic [NUM_SPR*12-1:0]     spr_data,
  output logic [OVL_AW-1:0]         ovl_addr,
  input  logic [11:0]               ovl_data,
  output logic [BG_AW-1:0]          bg_addr,
  input  logic [11:0]               bg_data,
  output logic                      hsync_o,
  output logic                      vsync_o,
  output logic [3:0]                red,
  output logic [3:0]                green,
  output logic [3:0]                blue
);

  // Window bounds widened by one bit so right/bottom edges clip instead of wrapping.
  localparam logic [10:0] OVL_XS  = 11'(OVL_X0);
  localparam logic [10:0] OVL_XE  = 11'(OVL_X0 + OVL_W);
  localparam logic [10:0] OVL_YS  = 11'(OVL_Y0);
  localparam logic [10:0] OVL_YE  = 11'(OVL_Y0 + OVL_H);
  localparam logic [11:0] SPR_W12 = 12'(SPR_W);
  localparam logic [10:0] SPR_H11 = 11'(SPR_H);

  logic [10:0]         sh_x_r  [NUM_SPR];
  logic [9:0]          sh_y_r  [NUM_SPR];
  logic [NUM_SPR-1:0]  sh_en_r;
  logic [10:0]         act_x_r [NUM_SPR];
  logic [9:0]          act_y_r [NUM_SPR];
  logic [NUM_SPR-1:0]  act_en_r;
  logic                pending_r;

  logic [10:0]         px_s;
  logic [10:0]         py_s;
  logic [10:0]         dx_s [NUM_SPR];
  logic [9:0]          dy_s [NUM_SPR];
  logic [NUM_SPR-1:0]  hit_s;
  logic [SPR_AW-1:0]   spr_addr_s [NUM_SPR];
  logic                ovl_hit_s;
  logic [OVL_AW-1:0]   ovl_addr_s;
  logic [BG_AW-1:0]    bg_addr_s;

  logic [NUM_SPR-1:0]  hit1_r, hit2_r;
  logic                ovl_hit1_r, ovl_hit2_r;
  logic                von1_r, von2_r, hs1_r, hs2_r, vs1_r, vs2_r;

  logic [NUM_SPR-1:0]  opaque_s;
  logic [11:0]         spr_pix_s;
  logic                spr_found_s;
  logic [11:0]         pix_s;
  logic [11:0]         rgb_r;

  // Shadow writes, commit request tracking and the atomic shadow->active copy.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        sh_x_r[i]  <= 11'd0;
        sh_y_r[i]  <= 10'd0;
        act_x_r[i] <= 11'd0;
        act_y_r[i] <= 10'd0;
      end
      sh_en_r    <= {NUM_SPR{1'b0}};
      act_en_r   <= {NUM_SPR{1'b0}};
      pending_r  <= 1'b0;
      commit_ack <= 1'b0;
    end else begin
      commit_ack <= 1'b0;
      if (frame_start && pending_r) begin
        for (int i = 0; i < NUM_SPR; i++) begin
          act_x_r[i] <= sh_x_r[i];
          act_y_r[i] <= sh_y_r[i];
        end
        act_en_r   <= sh_en_r;
        pending_r  <= 1'b0;
        commit_ack <= 1'b1;
      end else if (cfg_commit) begin
        pending_r <= 1'b1;
      end
      // Copy above reads the pre-write shadow, so a same-cycle write lands only in shadow.
      if (cfg_we && (int'(cfg_idx) < NUM_SPR)) begin
        sh_x_r[cfg_idx]  <= cfg_x;
        sh_y_r[cfg_idx]  <= cfg_y;
        sh_en_r[cfg_idx] <= cfg_en;
      end
    end
  end

  // Stage-1 decode: per-layer hit test and ROM address for the presented pixel.
  always_comb begin
    px_s = {1'b0, pixel_x};
    py_s = {1'b0, pixel_y};
    for (int i = 0; i < NUM_SPR; i++) begin
      dx_s[i]  = px_s - act_x_r[i];
      dy_s[i]  = pixel_y - act_y_r[i];
      hit_s[i] = act_en_r[i]
              && (px_s >= act_x_r[i]) && ({1'b0, px_s} < ({1'b0, act_x_r[i]} + SPR_W12))
              && (pixel_y >= act_y_r[i]) && (py_s < ({1'b0, act_y_r[i]} + SPR_H11));
      spr_addr_s[i] = hit_s[i] ? (SPR_AW'(dy_s[i]) * SPR_AW'(SPR_W) + SPR_AW'(dx_s[i]))
                               : {SPR_AW{1'b0}};
    end
    ovl_hit_s  = ovl_en && (px_s >= OVL_XS) && (px_s < OVL_XE)
                        && (py_s >= OVL_YS) && (py_s < OVL_YE);
    ovl_addr_s = ovl_hit_s ? (OVL_AW'(py_s - OVL_YS) * OVL_AW'(OVL_W) + OVL_AW'(px_s - OVL_XS))
                           : {OVL_AW{1'b0}};
    bg_addr_s  = BG_AW'(pixel_y) * BG_AW'(10'd640) + BG_AW'(pixel_x);
  end

  // Stage 1 register: ROM addresses out, hit flags and timing carried alongside.
  always_ff @(posedge clk) begin
    if (clr) begin
      spr_addr   <= {(NUM_SPR*SPR_AW){1'b0}};
      ovl_addr   <= {OVL_AW{1'b0}};
      bg_addr    <= {BG_AW{1'b0}};
      hit1_r     <= {NUM_SPR{1'b0}};
      ovl_hit1_r <= 1'b0;
      von1_r     <= 1'b0;
      hs1_r      <= 1'b1;
      vs1_r      <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_SPR; i++) begin
        spr_addr[i*SPR_AW +: SPR_AW] <= spr_addr_s[i];
      end
      ovl_addr   <= ovl_addr_s;
      bg_addr    <= bg_addr_s;
      hit1_r     <= hit_s;
      ovl_hit1_r <= ovl_hit_s;
      von1_r     <= video_on;
      hs1_r      <= hsync_i;
      vs1_r      <= vsync_i;
    end
  end

  // Stage 2 register: flags wait one clock for the ROM data to arrive.
  always_ff @(posedge clk) begin
    if (clr) begin
      hit2_r     <= {NUM_SPR{1'b0}};
      ovl_hit2_r <= 1'b0;
      von2_r     <= 1'b0;
      hs2_r      <= 1'b1;
      vs2_r      <= 1'b1;
    end else begin
      hit2_r     <= hit1_r;
      ovl_hit2_r <= ovl_hit1_r;
      von2_r     <= von1_r;
      hs2_r      <= hs1_r;
      vs2_r      <= vs1_r;
    end
  end

  // Layer select: overlay, then lowest-index opaque sprite, then background; blank outside video.
  always_comb begin
    spr_pix_s   = 12'h000;
    spr_found_s = 1'b0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      opaque_s[i] = hit2_r[i] && (spr_data[i*12 +: 12] != TRANSP_KEY);
      spr_pix_s   = opaque_s[i] ? spr_data[i*12 +: 12] : spr_pix_s;
      spr_found_s = spr_found_s | opaque_s[i];
    end
    if (!von2_r) begin
      pix_s = 12'h000;
    end else if (ovl_hit2_r) begin
      pix_s = ovl_data;
    end else if (spr_found_s) begin
      pix_s = spr_pix_s;
    end else begin
      pix_s = bg_data;
    end
  end

  // Stage 3 register: final pixel and syncs, aligned to the same clock.
  always_ff @(posedge clk) begin
    if (clr) begin
      rgb_r   <= 12'h000;
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
    end else begin
      rgb_r   <= pix_s;
      hsync_o <= hs2_r;
      vsync_o <= vs2_r;
    end
  end

  assign red   = rgb_r[3:0];
  assign green = rgb_r[7:4];
  assign blue  = rgb_r[11:8];

endmodule

// File: tb/tb_sprite_compositor.sv
// Testbench for sprite_compositor: directed steps followed by a randomized run,
// checked against a pixel-level reference model and modelled ROMs.
`timescale 1ns/1ps
module tb_sprite_compositor;
  localparam int NS = 4;
  localparam int AW = 11;

  logic clk = 1'b0;
  logic clr, video_on, hsync_i, vsync_i, frame_start;
  logic [9:0] pixel_x, pixel_y;
  logic cfg_we, cfg_en, cfg_commit, ovl_en;
  logic [1:0] cfg_idx;
  logic [10:0] cfg_x;
  logic [9:0] cfg_y;
  logic commit_ack, hsync_o, vsync_o;
  logic [NS*AW-1:0] spr_addr;
  logic [NS*12-1:0] spr_data = '0;
  logic [14:0] ovl_addr;
  logic [11:0] ovl_data = 12'h000;
  logic [18:0] bg_addr;
  logic [11:0] bg_data = 12'h000;
  logic [3:0] red, green, blue;

  int n_assert = 0;
  int n_fail = 0;

  bit rom_const = 1'b1;
  logic [11:0] spr_const [NS];

  // Reference configuration state (shadow, active, pending)
  int m_sx[NS], m_sy[NS], m_ax[NS], m_ay[NS];
  bit m_se[NS], m_ae[NS];
  bit m_pend;

  typedef struct packed { logic [11:0] rgb; logic hs; logic vs; } exp_t;
  exp_t exp_q[$];

  sprite_compositor dut (
    .clk(clk), .clr(clr), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .frame_start(frame_start),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_en(cfg_en),
    .cfg_commit(cfg_commit), .commit_ack(commit_ack), .ovl_en(ovl_en),
    .spr_addr(spr_addr), .spr_data(spr_data), .ovl_addr(ovl_addr), .ovl_data(ovl_data),
    .bg_addr(bg_addr), .bg_data(bg_data), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  // ROM contents
  function automatic logic [11:0] spr_rom(int i, int a);
    if (rom_const) return spr_const[i];
    if ((a % 7) == i) return 12'h000;
    return 12'((a * 97 + i * 1031 + 5) ^ (a >> 3)) | 12'h001;
  endfunction
  function automatic logic [11:0] ovl_rom(int a);
    return 12'(a * 29 + 300);
  endfunction
  function automatic logic [11:0] bg_rom(int a);
    return 12'(a * 13 + 7);
  endfunction

  // Synchronous ROMs with one clock of read latency
  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) spr_data[i*12 +: 12] <= spr_rom(i, int'(spr_addr[i*AW +: AW]));
    ovl_data <= ovl_rom(int'(ovl_addr));
    bg_data  <= bg_rom(int'(bg_addr));
  end

  function automatic bit m_hit(int i, int x, int y);
    return m_ae[i] && x >= m_ax[i] && x < m_ax[i] + 40 && y >= m_ay[i] && y < m_ay[i] + 40;
  endfunction
  function automatic bit m_ovl(int x, int y, bit oen);
    return oen && x >= 220 && x < 420 && y >= 190 && y < 290;
  endfunction
  function automatic logic [11:0] model_rgb(int x, int y, bit von, bit oen);
    logic [11:0] v;
    if (!von) return 12'h000;
    if (m_ovl(x, y, oen)) return ovl_rom((y - 190) * 200 + (x - 220));
    for (int i = 0; i < NS; i++) begin
      if (m_hit(i, x, y)) begin
        v = spr_rom(i, (y - m_ay[i]) * 40 + (x - m_ax[i]));
        if (v != 12'h000) return v;
      end
    end
    return bg_rom(y * 640 + x);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: predict, advance the model, then check everything the DUT exposes.
  task automatic tick();
    exp_t e, r;
    logic exp_ack;
    int ea[NS];
    int ebg, eo, px, py;
    bit eoh;
    px = int'(pixel_x);
    py = int'(pixel_y);
    e.rgb = model_rgb(px, py, video_on, ovl_en);
    e.hs = hsync_i;
    e.vs = vsync_i;
    for (int i = 0; i < NS; i++) ea[i] = m_hit(i, px, py) ? (py - m_ay[i]) * 40 + (px - m_ax[i]) : 0;
    ebg = py * 640 + px;
    eoh = m_ovl(px, py, ovl_en);
    eo = (py - 190) * 200 + (px - 220);
    exp_ack = frame_start && m_pend;
    if (clr) begin
      exp_ack = 1'b0;
      ebg = 0;
      eoh = 1'b0;
      for (int i = 0; i < NS; i++) ea[i] = 0;
    end
    @(posedge clk);
    if (clr) begin
      r.rgb = 12'h000; r.hs = 1'b1; r.vs = 1'b1;
      exp_q.delete();
      repeat (3) exp_q.push_back(r);
      for (int i = 0; i < NS; i++) begin
        m_sx[i] = 0; m_sy[i] = 0; m_se[i] = 0; m_ax[i] = 0; m_ay[i] = 0; m_ae[i] = 0;
      end
      m_pend = 0;
    end else begin
      exp_q.push_back(e);
      if (frame_start && m_pend) begin
        for (int i = 0; i < NS; i++) begin
          m_ax[i] = m_sx[i]; m_ay[i] = m_sy[i]; m_ae[i] = m_se[i];
        end
        m_pend = 0;
      end else if (cfg_commit) begin
        m_pend = 1;
      end
      if (cfg_we) begin
        m_sx[cfg_idx] = int'(cfg_x); m_sy[cfg_idx] = int'(cfg_y); m_se[cfg_idx] = cfg_en;
      end
    end
    @(negedge clk);
    chk("commit_ack", 32'(commit_ack), 32'(exp_ack));
    for (int i = 0; i < NS; i++) chk($sformatf("spr_addr%0d", i), 32'(spr_addr[i*AW +: AW]), 32'(ea[i]));
    chk("bg_addr", 32'(bg_addr), 32'(ebg));
    if (eoh) chk("ovl_addr", 32'(ovl_addr), 32'(eo));
    if (exp_q.size() >= 3) begin
      r = exp_q.pop_front();
      chk("rgb", 32'({blue, green, red}), 32'(r.rgb));
      chk("hsync_o", 32'(hsync_o), 32'(r.hs));
      chk("vsync_o", 32'(vsync_o), 32'(r.vs));
    end
  endtask

  task automatic set_pix(input int x, input int y);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    video_on = 1'b1;
    hsync_i = 1'($urandom_range(0, 1));
    vsync_i = 1'($urandom_range(0, 1));
  endtask

  task automatic show(input int x, input int y);
    set_pix(x, y);
    repeat (3) tick();
  endtask

  task automatic cfg_write(input int i, input int x, input int y, input bit en);
    cfg_we = 1'b1; cfg_idx = 2'(i); cfg_x = 11'(x); cfg_y = 10'(y); cfg_en = en;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic commit_now();
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  // Blank two pixels so no in-flight pixel straddles a ROM content change.
  task automatic flush();
    video_on = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    spr_const[0] = 12'h0F0; spr_const[1] = 12'h00F; spr_const[2] = 12'h0AB; spr_const[3] = 12'h555;
    clr = 1'b1; pixel_x = 10'd0; pixel_y = 10'd0; video_on = 1'b0; hsync_i = 1'b1; vsync_i = 1'b1;
    frame_start = 1'b0; cfg_we = 1'b0; cfg_idx = 2'd0; cfg_x = 11'd0; cfg_y = 10'd0; cfg_en = 1'b0;
    cfg_commit = 1'b0; ovl_en = 1'b0;
    m_pend = 0;

    // Reset state
    tick(); tick();
    clr = 1'b0;
    chk("reset_rgb", 32'({blue, green, red}), 32'h0);

    // Sprite 0 at (100,100), ROM green
    cfg_write(0, 100, 100, 1'b1);
    commit_now();
    set_pix(100, 100); tick();
    chk("t1_addr0", 32'(spr_addr[10:0]), 32'd0);
    tick(); tick();
    chk("t1_green", 32'(green), 32'hF);

    // Overlap priority with transparency
    cfg_write(1, 110, 100, 1'b1);
    commit_now();
    flush(); spr_const[0] = 12'h000;
    show(120, 110);
    chk("t2_red", 32'(red), 32'hF);
    flush(); spr_const[0] = 12'hF00;
    show(120, 110);
    chk("t2_blue", 32'(blue), 32'hF);

    // Right-edge clipping, no wrap-around
    cfg_write(2, 620, 300, 1'b1);
    cfg_write(3, 630, 350, 1'b1);
    commit_now();
    set_pix(639, 300); tick();
    chk("t3_addr19", 32'(spr_addr[2*AW +: AW]), 32'd19);
    tick(); tick();
    chk("t3_edge_rgb", 32'({blue, green, red}), 32'h0AB);
    show(0, 350);
    chk("t3_nowrap", 32'({blue, green, red}), 32'(bg_rom(350 * 640)));

    // Mid-frame move takes effect only at frame_start
    cfg_write(0, 300, 100, 1'b1);
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    show(100, 100);
    chk("t4_old_pos", 32'(blue), 32'hF);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("t4_ack", 32'(commit_ack), 32'd1);
    tick();
    chk("t4_ack_pulse", 32'(commit_ack), 32'd0);
    show(100, 100);
    chk("t4_vacated", 32'({blue, green, red}), 32'(bg_rom(100 * 640 + 100)));
    show(300, 100);
    chk("t4_new_pos", 32'(blue), 32'hF);

    // Overlay over an enabled sprite
    cfg_write(1, 220, 190, 1'b1);
    commit_now();
    ovl_en = 1'b1;
    show(220, 190);
    chk("t5_ovl", 32'({blue, green, red}), 32'(ovl_rom(0)));
    ovl_en = 1'b0;
    show(220, 190);
    chk("t5_spr", 32'({blue, green, red}), 32'h00F);

    // Commit coinciding with frame_start while not pending waits one frame
    cfg_write(3, 100, 100, 1'b1);
    cfg_commit = 1'b1; frame_start = 1'b1; tick(); cfg_commit = 1'b0; frame_start = 1'b0;
    tick();
    chk("t6_no_ack", 32'(commit_ack), 32'd0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("t6_ack", 32'(commit_ack), 32'd1);
    show(100, 100);
    chk("t6_spr3", 32'({blue, green, red}), 32'h555);

    // Write in the copy cycle reaches only the shadow
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    frame_start = 1'b1;
    cfg_write(3, 400, 100, 1'b1);
    frame_start = 1'b0;
    chk("t7_ack", 32'(commit_ack), 32'd1);
    show(100, 100);
    chk("t7_old_copy", 32'({blue, green, red}), 32'h555);
    commit_now();
    show(400, 100);
    chk("t7_new_copy", 32'({blue, green, red}), 32'h555);

    // Repeated commit gives a single ack
    cfg_commit = 1'b1; tick(); tick(); tick(); cfg_commit = 1'b0;
    frame_start = 1'b1; tick();
    chk("t8_ack", 32'(commit_ack), 32'd1);
    tick(); frame_start = 1'b0;
    chk("t8_single", 32'(commit_ack), 32'd0);

    // Reset mid-line
    set_pix(400, 100); tick();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t9_rgb0", 32'({blue, green, red}), 32'h0);
    chk("t9_hs1", 32'(hsync_o), 32'd1);
    show(400, 100);
    chk("t9_disabled", 32'({blue, green, red}), 32'(bg_rom(100 * 640 + 400)));

    // Randomized run against the model
    flush();
    rom_const = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      cfg_we = ($urandom_range(0, 9) == 0);
      cfg_idx = 2'($urandom_range(0, 3));
      cfg_x = ($urandom_range(0, 4) == 0) ? 11'($urandom_range(590, 700)) : 11'($urandom_range(40, 260));
      cfg_y = 10'($urandom_range(40, 260));
      cfg_en = ($urandom_range(0, 4) != 0);
      frame_start = ($urandom_range(0, 19) == 0);
      cfg_commit = ($urandom_range(0, 9) == 0) && !(frame_start && m_pend);
      clr = ($urandom_range(0, 499) == 0);
      ovl_en = 1'($urandom_range(0, 1));
      video_on = ($urandom_range(0, 9) != 0);
      hsync_i = 1'($urandom_range(0, 1));
      vsync_i = 1'($urandom_range(0, 1));
      pixel_x = ($urandom_range(0, 9) < 7) ? 10'($urandom_range(50, 300)) : 10'($urandom_range(0, 639));
      pixel_y = ($urandom_range(0, 9) < 7) ? 10'($urandom_range(50, 300)) : 10'($urandom_range(0, 479));
      tick();
    end
    cfg_we = 1'b0; cfg_commit = 1'b0; frame_start = 1'b0; clr = 1'b0; video_on = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
